fetch_unit: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the PC register, the IF/ID pipeline register and a one-entry skid buffer, and issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake. It consumes `StallF`, `StallD` and `FlushD` from the hazard unit, plus `PCSrcD`, `JumpD` and the targets from decode. It feeds `InstrD`, `PCPlus4D` and `ValidD` to decode.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/fetch_skid_buf.sv | 33 +++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset PC default, fetch FSM states and the IF/ID register layout.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } fetchState_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcPlus4;
        logic        valid;
    } ifId_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pcplus4} buffer catching a response that lands while decode is stalled.
module fetch_skid_buf
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        clear,
    input  logic [31:0] pushInstr,
    input  logic [31:0] pushPcPlus4,
    output logic        full,
    output logic [31:0] instr,
    output logic [31:0] pcPlus4
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full    <= 1'b0;
            instr   <= NOP_INSTR;
            pcPlus4 <= 32'h0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (push) begin
            full    <= 1'b1;
            instr   <= pushInstr;
            pcPlus4 <= pushPcPlus4;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC, single-outstanding imem handshake, IF/ID register, skid buffer.
// Define FETCH_PERF_EN to add saturating bubble/redirect performance counters.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcD,
    input  logic        JumpD,
    input  logic [31:0] PCBranchD,
    input  logic [31:0] PCJumpD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_bubble_cnt,
    output logic [31:0] perf_redirect_cnt
`endif
);

    fetchState_t state;
    ifId_t       ifId;
    logic [31:0] pc, fetchPc, target;
    logic [31:0] skidInstr, skidPcPlus4;
    logic        redirect, grant, keepResp, skidFull;

    // A stalled decode has not resolved its branch yet, so its flush is not acted on.
    assign redirect  = FlushD & ~StallD;
    assign target    = PCSrcD ? PCBranchD : PCJumpD;
    assign keepResp  = imem_rvalid & (state == WAIT) & ~redirect;

    assign imem_req  = ~rst & ((state == IDLE) | ((state == WAIT) & imem_rvalid))
                     & ~StallF & ~redirect & ~skidFull & ~(imem_rvalid & StallD);
    assign imem_addr = pc;
    assign grant     = imem_req & imem_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            fetchPc <= 32'h0;
        end else begin
            if (redirect)
                pc <= target;
            else if (grant)
                pc <= pc + 32'd4;
            if (grant)
                fetchPc <= pc;
            case (state)
                IDLE: if (grant) state <= WAIT;
                WAIT: begin
                    if (imem_rvalid)
                        state <= grant ? WAIT : IDLE;
                    else if (redirect)
                        state <= DROP;
                end
                DROP: if (imem_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    fetch_skid_buf uSkid (
        .clk        (clk),
        .rst        (rst),
        .push       (keepResp & StallD),
        .pop        (skidFull & ~StallD),
        .clear      (redirect),
        .pushInstr  (imem_rdata),
        .pushPcPlus4(fetchPc + 32'd4),
        .full       (skidFull),
        .instr      (skidInstr),
        .pcPlus4    (skidPcPlus4)
    );

    // A buffered instruction is older than anything on the bus, so it drains first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ifId <= '{NOP_INSTR, 32'h0, 1'b0};
        else if (!StallD) begin
            if (FlushD)
                ifId <= '{NOP_INSTR, 32'h0, 1'b0};
            else if (skidFull)
                ifId <= '{skidInstr, skidPcPlus4, 1'b1};
            else if (keepResp)
                ifId <= '{imem_rdata, fetchPc + 32'd4, 1'b1};
            else
                ifId <= '{NOP_INSTR, 32'h0, 1'b0};
        end
    end

    assign InstrD   = ifId.instr;
    assign PCPlus4D = ifId.pcPlus4;
    assign ValidD   = ifId.valid;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_bubble_cnt   <= 32'h0;
            perf_redirect_cnt <= 32'h0;
        end else begin
            if (!ValidD && !StallD && perf_bubble_cnt != 32'hFFFF_FFFF)
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            if (redirect && perf_redirect_cnt != 32'hFFFF_FFFF)
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a variable-latency imem model plus a queue-based fetch reference.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallF, StallD, FlushD, PCSrcD, JumpD;
    logic [31:0] PCBranchD, PCJumpD;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] InstrD, PCPlus4D;
    logic        ValidD;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_bubble_cnt, perf_redirect_cnt;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcD     (PCSrcD),
        .JumpD      (JumpD),
        .PCBranchD  (PCBranchD),
        .PCJumpD    (PCJumpD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .InstrD     (InstrD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
`ifdef FETCH_PERF_EN
        ,
        .perf_bubble_cnt  (perf_bubble_cnt),
        .perf_redirect_cnt(perf_redirect_cnt)
`endif
    );

    int nTests = 0;
    int nFail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Reference: requests in flight (with use/discard flag) and instructions waiting for decode.
    typedef struct { logic [31:0] addr; bit keep; } outReq_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc4; } entry_t;
    outReq_t     outQ[$];
    entry_t      heldQ[$];
    logic [31:0] mPc, mInstr, mPc4, mBubble, mRedir;
    bit          mValid;

    bit          memBusy = 0;
    int          memDelay;
    logic [31:0] memData;
    bit          staleFirst = 0;
    int          stallPct = 5;

    task automatic modelReset();
        mPc = RST_PC;
        outQ.delete();
        heldQ.delete();
        mInstr = 32'h0; mPc4 = 32'h0; mValid = 0;
        mBubble = 32'h0; mRedir = 32'h0;
    endtask

    function automatic bit expReq();
        bit redir    = FlushD & ~StallD;
        bit canIssue = (outQ.size() == 0) || (outQ[0].keep && imem_rvalid);
        return !rst && canIssue && !StallF && !redir && heldQ.size() == 0 && !(imem_rvalid && StallD);
    endfunction

    task automatic modelStep(input bit req);
        bit          redir = FlushD & ~StallD;
        bit          keepResp;
        entry_t      e;
        logic [31:0] tgt = PCSrcD ? PCBranchD : PCJumpD;
        keepResp = imem_rvalid && outQ.size() > 0 && outQ[0].keep && !redir;
        if (keepResp) e = '{imem_rdata, outQ[0].addr + 32'd4};
        if (!mValid && !StallD && mBubble != 32'hFFFF_FFFF) mBubble++;
        if (redir && mRedir != 32'hFFFF_FFFF) mRedir++;
        if (StallD) begin
            if (keepResp) heldQ.push_back(e);
        end else if (FlushD) begin
            mInstr = 32'h0; mPc4 = 32'h0; mValid = 0;
            heldQ.delete();
        end else if (heldQ.size() > 0) begin
            e = heldQ.pop_front();
            mInstr = e.instr; mPc4 = e.pc4; mValid = 1;
        end else if (keepResp) begin
            mInstr = e.instr; mPc4 = e.pc4; mValid = 1;
        end else begin
            mValid = 0;
        end
        if (imem_rvalid && outQ.size() > 0) void'(outQ.pop_front());
        if (redir) begin
            foreach (outQ[i]) outQ[i].keep = 0;
            mPc = tgt;
        end
        if (req && imem_gnt) begin
            outQ.push_back('{mPc, 1'b1});
            mPc = mPc + 32'd4;
        end
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst = 1; StallF = 0; StallD = 0; FlushD = 0; imem_rvalid = 0; imem_gnt = 1;
        #4;
        modelReset();
        chk("rst imem_req", imem_req, 0);
        chk("rst ValidD", ValidD, 0);
        chk("rst InstrD", InstrD, 0);
        chk("rst PCPlus4D", PCPlus4D, 0);
`ifdef FETCH_PERF_EN
        chk("rst perf_bubble", perf_bubble_cnt, 0);
        chk("rst perf_redirect", perf_redirect_cnt, 0);
`endif
        @(posedge clk);
        staleFirst = memBusy;
    endtask

    task automatic cycle();
        bit req;
        @(posedge clk); #1;
        rst    = 0;
        StallF = ($urandom % 100) < stallPct;
        StallD = ($urandom % 100) < stallPct + 10;
        FlushD = ($urandom % 100) < 10;
        PCSrcD = $urandom % 2;
        JumpD  = $urandom % 2;
        PCBranchD = ($urandom % 4 == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
        PCJumpD   = $urandom & 32'hFFFF_FFFC;
        imem_gnt  = ($urandom % 100) < 70;
        imem_rvalid = 0;
        imem_rdata  = $urandom;
        if (staleFirst) begin
            // Response to a request killed by reset; hold off fetch so it cannot overlap a new one.
            imem_rvalid = 1; imem_rdata = memData; memBusy = 0; StallF = 1; staleFirst = 0;
        end else if (memBusy) begin
            if (memDelay == 0) begin
                imem_rvalid = 1; imem_rdata = memData; memBusy = 0;
            end else begin
                memDelay--;
            end
        end
        #4;
        req = expReq();
        chk("imem_req", imem_req, req);
        if (req) chk("imem_addr", imem_addr, mPc);
        chk("ValidD", ValidD, mValid);
        if (mValid) begin
            chk("InstrD", InstrD, mInstr);
            chk("PCPlus4D", PCPlus4D, mPc4);
        end
`ifdef FETCH_PERF_EN
        chk("perf_bubble", perf_bubble_cnt, mBubble);
        chk("perf_redirect", perf_redirect_cnt, mRedir);
`endif
        if (imem_req && imem_gnt) begin
            memBusy  = 1;
            memDelay = $urandom % 4;
            memData  = memWord(imem_addr);
        end
        modelStep(req);
    endtask

    initial begin
        rst = 1; StallF = 0; StallD = 0; FlushD = 0; PCSrcD = 0; JumpD = 0;
        PCBranchD = 0; PCJumpD = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        modelReset();
        doReset();
        stallPct = 0;
        repeat (150) cycle();
        stallPct = 15;
        repeat (400) cycle();
        doReset();
        repeat (400) cycle();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
